// File: rtl/big_noc_pkg.sv
// Shared router definitions: flit format, port count and arbiter state encoding.
package big_noc_pkg;

  localparam int unsigned FLIT_W   = 11;
  localparam int unsigned TAIL_BIT = FLIT_W - 1;
  localparam int unsigned NREQ     = 5;
  localparam int unsigned CORE_IDX = 4;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_t;

endpackage

// File: rtl/big_merge_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  always_comb begin
    int unsigned cand;
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    // Walk offsets from far to near so the offset closest to ptr overrides.
    for (int k = N - 1; k >= 0; k--) begin
      cand = (32'(ptr) + 32'(k)) % N;
      if (req[cand[W-1:0]]) begin
        any = 1'b1;
        idx = W'(cand);
      end
    end
  end

endmodule

// File: rtl/big_merge_arbiter.sv
// Packet-locked round-robin merge of NREQ requesters onto one output channel,
// with a one-entry registered output stage and a delivered-packet counter.
module big_merge_arbiter
  import big_noc_pkg::*;
#(
  parameter int unsigned WIDTH = FLIT_W,
  parameter int unsigned NREQ  = big_noc_pkg::NREQ,
  parameter int unsigned SELW  = $clog2(NREQ),
  parameter int unsigned CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ*WIDTH-1:0] in_data,
  output logic [NREQ-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic                  grant_valid,
  output logic [SELW-1:0]       grant_sel,
  output logic [CNTW-1:0]       pkt_count
);

  arb_state_t       state_q, state_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNTW-1:0]  pkt_count_q;

  logic             pick_any;
  logic [SELW-1:0]  pick_idx;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] cur_flit;

  rr_pick #(
    .N (NREQ),
    .W (SELW)
  ) u_pick (
    .req (in_valid),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign cur_flit = in_data[sel_q*WIDTH +: WIDTH];
  // Output slot is free when empty or being drained this cycle.
  assign can_load = !out_valid_q || out_ready;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    in_ready = '0;
    load     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          state_d = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        in_ready[sel_q] = can_load;
        if (in_valid[sel_q] && can_load) begin
          load = 1'b1;
          if (cur_flit[WIDTH-1]) begin
            state_d = ARB_IDLE;
            ptr_d   = (sel_q == SELW'(NREQ - 1)) ? '0 : sel_q + SELW'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = cur_flit;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      if (out_valid_q && out_ready && out_data_q[WIDTH-1]) begin
        pkt_count_q <= pkt_count_q + CNTW'(1);
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign grant_valid = (state_q == ARB_LOCK);
  assign grant_sel   = sel_q;
  assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_big_merge_arbiter.sv
// Directed bench for big_merge_arbiter; inputs change and outputs are checked on negedges.
module tb_big_merge_arbiter;
  import big_noc_pkg::*;

  localparam int unsigned W  = FLIT_W;
  localparam int unsigned NR = big_noc_pkg::NREQ;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     in_valid;
  logic [NR*W-1:0]   in_data;
  logic [NR-1:0]     in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_ready;
  logic              grant_valid;
  logic [2:0]        grant_sel;
  logic [15:0]       pkt_count;

  int n_vec;
  int n_err;

  big_merge_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel),
    .pkt_count   (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_flit(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_order [6];
    n_vec     = 0;
    n_err     = 0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    exp_order = '{0, 1, 2, 3, 4, 0};

    // Reset state
    tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_grant_valid", 32'(grant_valid), 0);
    check("rst_grant_sel", 32'(grant_sel), 0);
    check("rst_pkt_count", 32'(pkt_count), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;

    // 3-flit packet on port 2
    in_valid = 5'b00100;
    set_flit(2, 11'h005);
    tick();
    check("p2_grant_valid", 32'(grant_valid), 1);
    check("p2_grant_sel", 32'(grant_sel), 2);
    check("p2_in_ready", 32'(in_ready), 32'b00100);
    check("p2_out_valid0", 32'(out_valid), 0);
    tick();
    check("p2_flit0", 32'(out_data), 32'h005);
    check("p2_out_valid1", 32'(out_valid), 1);
    set_flit(2, 11'h006);
    tick();
    check("p2_flit1", 32'(out_data), 32'h006);
    set_flit(2, 11'h407);
    tick();
    check("p2_flit2", 32'(out_data), 32'h407);
    check("p2_idle_gv", 32'(grant_valid), 0);
    check("p2_idle_ir", 32'(in_ready), 0);
    in_valid = '0;
    tick();
    check("p2_pkt_count", 32'(pkt_count), 1);
    check("p2_drained", 32'(out_valid), 0);

    // ptr=3 now: between ports 1 and 4, port 4 must win
    in_valid = 5'b10010;
    set_flit(1, 11'h401);
    set_flit(4, 11'h014);
    tick();
    check("ptr3_grant_sel", 32'(grant_sel), 4);
    check("ptr3_in_ready", 32'(in_ready), 32'b10000);
    tick();
    check("p4_flit0", 32'(out_data), 32'h014);

    // Asynchronous reset between edges, mid-packet
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_data", 32'(out_data), 0);
    check("arst_grant_valid", 32'(grant_valid), 0);
    check("arst_grant_sel", 32'(grant_sel), 0);
    check("arst_pkt_count", 32'(pkt_count), 0);
    check("arst_in_ready", 32'(in_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_restart_sel", 32'(grant_sel), 1);
    check("arst_restart_gv", 32'(grant_valid), 1);
    tick();
    check("arst_p1_flit", 32'(out_data), 32'h401);
    in_valid = '0;
    tick();
    check("arst_pkt_count1", 32'(pkt_count), 1);

    // All five ports streaming single-flit packets
    do_reset();
    for (int i = 0; i < 5; i++) set_flit(i, W'(11'h400 | i));
    in_valid = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_grant_sel", 32'(grant_sel), 32'(exp_order[k]));
      check("rr_grant_valid", 32'(grant_valid), 1);
      check("rr_in_ready", 32'(in_ready), 32'(1) << exp_order[k]);
      tick();
      check("rr_idle_ir", 32'(in_ready), 0);
      check("rr_out_data", 32'(out_data), 32'h400 | 32'(exp_order[k]));
    end
    in_valid = '0;
    tick();
    check("rr_pkt_count", 32'(pkt_count), 6);
    check("rr_drained", 32'(out_valid), 0);

    // Backpressure: port 3 packet with out_ready low for 4 cycles
    in_valid = 5'b01000;
    set_flit(3, 11'h031);
    tick();
    check("bp_grant_sel", 32'(grant_sel), 3);
    tick();
    check("bp_flit0", 32'(out_data), 32'h031);
    set_flit(3, 11'h032);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_data", 32'(out_data), 32'h031);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_ir", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_flit1", 32'(out_data), 32'h032);
    set_flit(3, 11'h433);
    tick();
    check("bp_flit2", 32'(out_data), 32'h433);
    in_valid = '0;
    tick();
    check("bp_pkt_count", 32'(pkt_count), 7);

    // Port 1 stalls mid-packet while port 0 waits
    in_valid = 5'b00010;
    set_flit(1, 11'h111);
    set_flit(0, 11'h400);
    tick();
    check("st_grant_sel", 32'(grant_sel), 1);
    in_valid = 5'b00011;
    tick();
    check("st_flit0", 32'(out_data), 32'h111);
    in_valid = 5'b00001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_hold_sel", 32'(grant_sel), 1);
      check("st_hold_gv", 32'(grant_valid), 1);
      check("st_hold_ir", 32'(in_ready), 32'b00010);
    end
    in_valid = 5'b00011;
    set_flit(1, 11'h512);
    tick();
    check("st_tail", 32'(out_data), 32'h512);
    check("st_tail_gv", 32'(grant_valid), 0);
    in_valid = 5'b00001;
    tick();
    check("st_next_sel", 32'(grant_sel), 0);
    check("st_next_gv", 32'(grant_valid), 1);
    tick();
    check("st_p0_flit", 32'(out_data), 32'h400);
    in_valid = '0;
    tick();
    check("st_pkt_count", 32'(pkt_count), 9);

    // Counter wrap
    force dut.pkt_count_q = 16'hFFFF;
    tick();
    check("wrap_preload", 32'(pkt_count), 32'hFFFF);
    release dut.pkt_count_q;
    in_valid = 5'b00100;
    set_flit(2, 11'h4AA);
    tick();
    check("wrap_grant_sel", 32'(grant_sel), 2);
    tick();
    check("wrap_flit", 32'(out_data), 32'h4AA);
    in_valid = '0;
    tick();
    check("wrap_pkt_count", 32'(pkt_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/big_merge_arbiter.md
Name: big_merge_arbiter

Overview:
- Packet-level round-robin arbiter that shares one router output channel between five requesters: four directional input ports (0..3) and the local core (4).
- It is the merge-side counterpart to the big split stage. It locks a grant for a whole multi-flit packet, forwards flits through a one-entry registered output stage, and counts delivered packets.
- It sits between the input buffers and the output link of each router.

Parameters:
- WIDTH, 11, flit width in bits; bit WIDTH-1 is the tail flag.
- NREQ, 5, number of requesters; index NREQ-1 is the core port.
- SELW, $clog2(NREQ) (=3), width of the grant index.
- CNTW, 16, width of the delivered-packet counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  NREQ  per-requester flit valid.
- in_data  in  NREQ*WIDTH  packed flits; requester i occupies [i*WIDTH +: WIDTH].
- in_ready  out  NREQ  per-requester accept; a flit transfers when in_valid[i] && in_ready[i].
- out_valid  out  1  output flit valid (registered).
- out_data  out  WIDTH  output flit (registered).
- out_ready  in  1  downstream accept.
- grant_valid  out  1  a packet grant is held (state LOCK).
- grant_sel  out  SELW  index of the granted requester; held at the last value when grant_valid=0.
- pkt_count  out  CNTW  number of tail flits delivered downstream; wraps modulo 2^CNTW.

Behaviour:
- Reset (rst_n=0, asynchronous; takes effect immediately, including mid-packet):
  - state=IDLE, ptr=0.
  - out_valid=0, out_data=0, grant_valid=0, grant_sel=0, pkt_count=0, in_ready=0.
  - A partially sent packet is abandoned. Upstream is responsible for re-sending it.
- FSM states: IDLE, LOCK.
- IDLE:
  - in_ready=0.
  - If any in_valid is high, choose the first set bit searching ptr, ptr+1, ..., NREQ-1, 0, ... (wrapping).
  - Next cycle: grant_sel=winner, grant_valid=1, state=LOCK.
  - Arbitration costs exactly one cycle.
  - With no requests, the FSM stays in IDLE.
- LOCK:
  - in_ready[grant_sel] = !out_valid || out_ready. All other in_ready bits are 0.
  - On an input transfer, the output register loads the flit and out_valid=1 next cycle. Latency is 1 cycle, and full throughput is 1 flit/cycle.
  - If out_valid && out_ready with no new input transfer, out_valid=0 next cycle.
  - When a flit with flit[WIDTH-1]=1 (tail) is accepted from the input: state=IDLE, grant_valid=0, ptr=(grant_sel+1) mod NREQ.
  - A single-flit packet is header and tail at once.
- pkt_count increments when out_valid && out_ready && out_data[WIDTH-1]=1. It wraps from 2^CNTW-1 to 0.
- Output stage:
  - out_data/out_valid are stable while out_valid && !out_ready (no drop, no change).
  - The output register may still drain the tail flit while the FSM is in IDLE or re-arbitrating.
- Simultaneous events:
  - Tail accept and a new arbitration never occur in the same cycle. There is a minimum 1-cycle gap between packets at the input side.
  - An output drain and an input load in the same cycle leave out_valid=1 with the new flit.
- Fairness: the winner moves to the lowest priority after its packet. Any continuously requesting port is granted within NREQ-1 packets.
- Deasserting in_valid mid-packet keeps the lock. The arbiter waits indefinitely for the tail.
- in_valid for non-granted ports is ignored in LOCK.

Decomposition:
- Shared package big_noc_pkg holds:
  - FLIT_W=11, TAIL_BIT=FLIT_W-1, NREQ=5, CORE_IDX=4.
  - typedef flit_t (logic [FLIT_W-1:0]).
  - typedef enum {ARB_IDLE, ARB_LOCK} arb_state_t.
- One sub-module, rr_pick: combinational round-robin priority picker (inputs req, ptr; outputs any, idx). It is reusable by the split-side controller.

Test Plan:
- Reset, then assert in_valid[2] with a 3-flit packet 0x005, 0x006, 0x407 and out_ready=1.
  - grant_sel=2 one cycle after request.
  - out_data shows 0x005, 0x006, 0x407 on consecutive cycles.
  - pkt_count=1; return to IDLE, ptr=3.
- All 5 requesters continuously send 1-flit packets (0x400|i).
  - Grant order 0, 1, 2, 3, 4, 0.
  - pkt_count=6 after six packets.
  - No in_ready to non-granted ports.
- Backpressure: hold out_ready=0 for 4 cycles mid-packet.
  - out_data stays constant and in_ready[grant_sel]=0 while out_valid=1.
  - On resume, no flit is lost or duplicated.
- Requester 1 drops in_valid for 3 cycles mid-packet while requester 0 is valid.
  - Grant stays on 1 until its tail is accepted.
  - Requester 0 is granted next.
- Assert rst_n=0 asynchronously mid-packet (between clock edges).
  - All outputs clear immediately to their reset values.
  - After release, arbitration restarts from ptr=0.
- Preload the counter to 0xFFFF (force) and send a single tail flit.
  - pkt_count wraps to 0x0000.
